// File: rtl/time_keeper_pkg.sv
// Shared time-of-day limits, set_mode encodings and BCD helpers for the time_keeper slice.
package time_keeper_pkg;

    localparam logic [7:0] SEC_MAX  = 8'h59;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    localparam logic [7:0] HOUR_MAX = 8'h23;

    typedef enum logic [1:0] {
        MODE_RUN   = 2'b00,
        MODE_SET_H = 2'b01,
        MODE_SET_M = 2'b10,
        MODE_SET_S = 2'b11
    } set_mode_e;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] >= 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end else begin
            return {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

    // Both nibbles must be decimal digits and the whole value must not exceed max.
    function automatic logic bcd_in_range(input logic [7:0] v, input logic [7:0] max);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
    endfunction

endpackage

// File: rtl/time_keeper_bcd_mod_counter.sv
// Two-digit BCD modulo counter used for each time_keeper field.
module time_keeper_bcd_mod_counter
    import time_keeper_pkg::*;
#(
    parameter logic [7:0] MAX = 8'h59,
    parameter logic [7:0] RST = 8'h00
) (
    input  logic       clk,
    input  logic       cr,
    input  logic       inc,
    input  logic       clr,
    input  logic       ld,
    input  logic [7:0] ld_val,
    output logic [7:0] value,
    output logic       wrap
);

    logic [7:0] value_r;

    // Field register: reset, load, clear, then increment with wrap at MAX.
    always_ff @(posedge clk) begin
        if (!cr) begin
            value_r <= RST;
        end else if (ld) begin
            value_r <= ld_val;
        end else if (clr) begin
            value_r <= 8'h00;
        end else if (inc) begin
            value_r <= (value_r == MAX) ? 8'h00 : bcd_inc(value_r);
        end else begin
            value_r <= value_r;
        end
    end

    assign value = value_r;
    assign wrap  = inc && (value_r == MAX);

endmodule

// File: rtl/time_keeper.sv
// 24-hour BCD time-of-day counter at 1 Hz with field adjust, validated load and carry pulses.
module time_keeper
    import time_keeper_pkg::*;
#(
    parameter logic [7:0] RESET_HOUR = 8'h00,
    parameter logic [7:0] RESET_MIN  = 8'h00,
    parameter logic [7:0] RESET_SEC  = 8'h00
) (
    input  logic       clk_1hz,
    input  logic       cr,
    input  logic       en,
    input  logic [1:0] set_mode,
    input  logic       adj,
    input  logic       load,
    input  logic [7:0] load_hour,
    input  logic [7:0] load_min,
    input  logic [7:0] load_sec,
    output logic [7:0] hour,
    output logic [7:0] minute,
    output logic [7:0] second,
    output logic       min_carry,
    output logic       hour_carry,
    output logic       day_carry,
    output logic       load_ack,
    output logic       load_err
);

    set_mode_e mode_s;
    logic      load_ok_s;
    logic      ld_s;
    logic      run_s;
    logic      sec_inc_s, min_inc_s, hour_inc_s, sec_clr_s;
    logic      sec_wrap_s, min_wrap_s, hour_wrap_s;
    logic      min_carry_r, hour_carry_r, day_carry_r, load_ack_r, load_err_r;

    assign mode_s    = set_mode_e'(set_mode);
    assign load_ok_s = bcd_in_range(load_hour, HOUR_MAX) &&
                       bcd_in_range(load_min, MIN_MAX) &&
                       bcd_in_range(load_sec, SEC_MAX);
    assign ld_s      = load && load_ok_s;

    // Mode decode: load (valid or not) suppresses all run and adjust activity.
    always_comb begin
        run_s      = 1'b0;
        sec_inc_s  = 1'b0;
        sec_clr_s  = 1'b0;
        min_inc_s  = 1'b0;
        hour_inc_s = 1'b0;
        if (load) begin
            run_s = 1'b0;
        end else begin
            case (mode_s)
                MODE_RUN: begin
                    run_s      = en;
                    sec_inc_s  = en;
                    min_inc_s  = en && sec_wrap_s;
                    hour_inc_s = en && sec_wrap_s && min_wrap_s;
                end
                MODE_SET_H: hour_inc_s = adj;
                MODE_SET_M: min_inc_s  = adj;
                MODE_SET_S: sec_clr_s  = adj;
                default:    run_s      = 1'b0;
            endcase
        end
    end

    time_keeper_bcd_mod_counter #(.MAX(SEC_MAX), .RST(RESET_SEC)) u_sec (
        .clk(clk_1hz), .cr(cr), .inc(sec_inc_s), .clr(sec_clr_s), .ld(ld_s),
        .ld_val(load_sec), .value(second), .wrap(sec_wrap_s)
    );

    time_keeper_bcd_mod_counter #(.MAX(MIN_MAX), .RST(RESET_MIN)) u_min (
        .clk(clk_1hz), .cr(cr), .inc(min_inc_s), .clr(1'b0), .ld(ld_s),
        .ld_val(load_min), .value(minute), .wrap(min_wrap_s)
    );

    time_keeper_bcd_mod_counter #(.MAX(HOUR_MAX), .RST(RESET_HOUR)) u_hour (
        .clk(clk_1hz), .cr(cr), .inc(hour_inc_s), .clr(1'b0), .ld(ld_s),
        .ld_val(load_hour), .value(hour), .wrap(hour_wrap_s)
    );

    // Pulse registers; carries only come from genuine run cascades, never from adjusts.
    always_ff @(posedge clk_1hz) begin
        if (!cr) begin
            min_carry_r  <= 1'b0;
            hour_carry_r <= 1'b0;
            day_carry_r  <= 1'b0;
            load_ack_r   <= 1'b0;
            load_err_r   <= 1'b0;
        end else begin
            min_carry_r  <= run_s && sec_wrap_s;
            hour_carry_r <= run_s && sec_wrap_s && min_wrap_s;
            day_carry_r  <= run_s && sec_wrap_s && min_wrap_s && hour_wrap_s;
            load_ack_r   <= ld_s;
            load_err_r   <= load && !load_ok_s;
        end
    end

    assign min_carry  = min_carry_r;
    assign hour_carry = hour_carry_r;
    assign day_carry  = day_carry_r;
    assign load_ack   = load_ack_r;
    assign load_err   = load_err_r;

endmodule

// File: tb/tb_time_keeper.sv
// Scoreboard bench for time_keeper: directed vectors push expected state, a monitor pops and compares.
module tb_time_keeper;

    logic       clk_1hz = 1'b0;
    logic       cr = 1'b0, en = 1'b0, adj = 1'b0, load = 1'b0;
    logic [1:0] set_mode = 2'b00;
    logic [7:0] load_hour = 8'h00, load_min = 8'h00, load_sec = 8'h00;
    logic [7:0] hour, minute, second;
    logic       min_carry, hour_carry, day_carry, load_ack, load_err;

    typedef struct packed {
        logic [23:0] t;
        logic [4:0]  p;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    localparam logic [4:0] NONE = 5'b00000;
    localparam logic [4:0] MINC = 5'b10000;
    localparam logic [4:0] HRC  = 5'b01000;
    localparam logic [4:0] DAYC = 5'b00100;
    localparam logic [4:0] ACK  = 5'b00010;
    localparam logic [4:0] ERR  = 5'b00001;

    time_keeper #(.RESET_HOUR(8'h00), .RESET_MIN(8'h00), .RESET_SEC(8'h00)) dut (
        .clk_1hz(clk_1hz), .cr(cr), .en(en), .set_mode(set_mode), .adj(adj),
        .load(load), .load_hour(load_hour), .load_min(load_min), .load_sec(load_sec),
        .hour(hour), .minute(minute), .second(second),
        .min_carry(min_carry), .hour_carry(hour_carry), .day_carry(day_carry),
        .load_ack(load_ack), .load_err(load_err)
    );

    always #5 clk_1hz = ~clk_1hz;

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every edge after stimulus presents a new output set.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_1hz);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("time", {hour, minute, second}, e.t);
                chk("pulses", {19'd0, min_carry, hour_carry, day_carry, load_ack, load_err},
                    {19'd0, e.p});
            end
        end
    end

    task automatic step(input logic c, input logic e, input logic [1:0] md, input logic a,
                        input logic l, input logic [23:0] ld, input logic [23:0] t,
                        input logic [4:0] p);
        exp_t x;
        @(negedge clk_1hz);
        cr        = c;
        en        = e;
        set_mode  = md;
        adj       = a;
        load      = l;
        load_hour = ld[23:16];
        load_min  = ld[15:8];
        load_sec  = ld[7:0];
        x.t = t;
        x.p = p;
        q.push_back(x);
    endtask

    initial begin
        // reset, then reset mid-count
        step(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 24'h000000, 24'h000000, NONE);
        step(1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 24'h123456, 24'h123456, ACK);
        step(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 24'h000000, 24'h123457, NONE);
        step(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 24'h000000, 24'h000000, NONE);
        step(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 24'h000000, 24'h000001, NONE);
        // day roll-over cascade
        step(1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 24'h235958, 24'h235958, ACK);
        step(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 24'h000000, 24'h235959, NONE);
        step(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 24'h000000, 24'h000000, MINC | HRC | DAYC);
        step(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 24'h000000, 24'h000001, NONE);
        // invalid loads leave time untouched, even though run is enabled
        step(1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 24'h121A00, 24'h000001, ERR);
        step(1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 24'h126000, 24'h000001, ERR);
        step(1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 24'h240000, 24'h000001, ERR);
        step(1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 24'h12300A, 24'h000001, ERR);
        step(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 24'h000000, 24'h000002, NONE);
        // minute-only and minute+hour carries
        step(1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 24'h100059, 24'h100059, ACK);
        step(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 24'h000000, 24'h100100, MINC);
        step(1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 24'h105959, 24'h105959, ACK);
        step(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 24'h000000, 24'h110000, MINC | HRC);
        // set hour wraps 23->00 without day_carry, ignores en
        step(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 24'h231045, 24'h231045, ACK);
        step(1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 24'h000000, 24'h001045, NONE);
        step(1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 24'h000000, 24'h011045, NONE);
        step(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 24'h000000, 24'h011045, NONE);
        // set minute wraps 59->00 with no hour change
        step(1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 24'h015945, 24'h015945, ACK);
        step(1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 24'h000000, 24'h010045, NONE);
        // set second clears, then running resumes from the held value
        step(1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 24'h081545, 24'h081545, ACK);
        step(1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 24'h000000, 24'h081500, NONE);
        step(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 24'h000000, 24'h081501, NONE);
        // en=0 holds; reset beats a simultaneous load
        step(1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 24'h100000, 24'h100000, ACK);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 24'h000000, 24'h100000, NONE);
        end
        step(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 24'h120000, 24'h000000, NONE);
        step(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 24'h000000, 24'h000000, NONE);
        step(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 24'h000000, 24'h000001, NONE);
        // drain the scoreboard with a bounded wait
        begin
            int budget;
            budget = 0;
            while (q.size() > 0 && budget < 10) begin
                @(posedge clk_1hz);
                budget++;
            end
            #3;
            if (q.size() > 0) begin
                failures++;
                $display("FAIL drain: %0d expectations left, required 0", q.size());
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
